// File: rtl/uart_frame_ctrl_pkg.sv
// Shared UART framing definitions: parser states, default sync marker and
// payload sizing used by the frame controller and its timeout counter.
package uart_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    S_SYNC    = 3'd0,
    S_ADDR    = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CHK     = 3'd4
  } frame_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         MAX_LEN_LIMIT     = 8;
  localparam int         IDX_W             = $clog2(MAX_LEN_LIMIT);
  localparam int         DATA_W            = 8 * MAX_LEN_LIMIT;
  localparam int         TIMEOUT_W         = 16;

endpackage

// File: rtl/uart_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles and emits a single expire pulse
// when the count reaches TIMEOUT_CLKS-1; a clear always wins over expiry.
module uart_byte_timeout
  import uart_frame_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CLKS = 1000
) (
  input  logic i_Clock,
  input  logic rst_n,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CLKS - 1);

  logic [TIMEOUT_W-1:0] r_Count;

  assign o_Expire = i_Enable && !i_Clear && (r_Count == LAST_COUNT);

  always_ff @(posedge i_Clock) begin
    if (!rst_n) begin
      r_Count <= '0;
    end else if (i_Clear || o_Expire) begin
      r_Count <= '0;
    end else if (i_Enable) begin
      r_Count <= r_Count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame parser for SYNC/ADDR/LEN/payload/CHK packets from a byte-level UART
// receiver; holds one completed frame for a ready/valid consumer.
module uart_frame_ctrl
  import uart_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN      = 8,
  parameter int         TIMEOUT_CLKS = 1000
) (
  input  logic              i_Clock,
  input  logic              rst_n,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  input  logic              i_Rx_Active,
  input  logic              i_Frame_Ready,
  output logic              o_Frame_Valid,
  output logic [7:0]        o_Addr,
  output logic [3:0]        o_Len,
  output logic [DATA_W-1:0] o_Data,
  output logic              o_Chk_Err,
  output logic              o_Len_Err,
  output logic              o_Timeout,
  output logic              o_Overrun,
  output logic              o_Busy
);

  frame_state_t      r_State;
  logic [7:0]        r_FrmAddr;
  logic [3:0]        r_FrmLen;
  logic [DATA_W-1:0] r_FrmData;
  logic [IDX_W-1:0]  r_Idx;
  logic [7:0]        r_Xor;
  logic              r_Valid;
  logic [7:0]        r_OutAddr;
  logic [3:0]        r_OutLen;
  logic [DATA_W-1:0] r_OutData;
  logic              r_ChkErr;
  logic              r_LenErr;
  logic              r_Timeout;
  logic              r_Overrun;

  logic w_Busy;
  logic w_Expire;
  logic w_TimerClear;
  logic w_LastByte;

  assign w_Busy       = (r_State != S_SYNC);
  assign w_TimerClear = i_Rx_DV || i_Rx_Active || !w_Busy;
  assign w_LastByte   = ({1'b0, r_Idx} == (r_FrmLen - 4'd1));

  uart_byte_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock (i_Clock),
    .rst_n   (rst_n),
    .i_Clear (w_TimerClear),
    .i_Enable(w_Busy),
    .o_Expire(w_Expire)
  );

  // A byte strobe always takes precedence over expiry; the timer never
  // expires on a strobe cycle because the strobe also clears it.
  always_ff @(posedge i_Clock) begin
    if (!rst_n) begin
      r_State   <= S_SYNC;
      r_FrmAddr <= '0;
      r_FrmLen  <= '0;
      r_FrmData <= '0;
      r_Idx     <= '0;
      r_Xor     <= '0;
      r_Valid   <= 1'b0;
      r_OutAddr <= '0;
      r_OutLen  <= '0;
      r_OutData <= '0;
      r_ChkErr  <= 1'b0;
      r_LenErr  <= 1'b0;
      r_Timeout <= 1'b0;
      r_Overrun <= 1'b0;
    end else begin
      r_ChkErr  <= 1'b0;
      r_LenErr  <= 1'b0;
      r_Timeout <= 1'b0;
      r_Overrun <= 1'b0;
      if (r_Valid && i_Frame_Ready) begin
        r_Valid <= 1'b0;
      end
      if (i_Rx_DV) begin
        case (r_State)
          S_SYNC: begin
            if (i_Rx_Byte == SYNC_BYTE) r_State <= S_ADDR;
          end
          S_ADDR: begin
            r_FrmAddr <= i_Rx_Byte;
            r_Xor     <= i_Rx_Byte;
            r_State   <= S_LEN;
          end
          S_LEN: begin
            if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_LEN))) begin
              r_LenErr <= 1'b1;
              r_State  <= S_SYNC;
            end else begin
              r_FrmLen  <= i_Rx_Byte[3:0];
              r_Xor     <= r_Xor ^ i_Rx_Byte;
              r_Idx     <= '0;
              r_FrmData <= '0;
              r_State   <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            r_FrmData[{r_Idx, 3'b000} +: 8] <= i_Rx_Byte;
            r_Xor <= r_Xor ^ i_Rx_Byte;
            r_Idx <= r_Idx + 1'b1;
            if (w_LastByte) r_State <= S_CHK;
          end
          S_CHK: begin
            r_State <= S_SYNC;
            if (i_Rx_Byte != r_Xor) begin
              r_ChkErr <= 1'b1;
            end else if (!r_Valid || i_Frame_Ready) begin
              r_OutAddr <= r_FrmAddr;
              r_OutLen  <= r_FrmLen;
              r_OutData <= r_FrmData;
              r_Valid   <= 1'b1;
            end else begin
              r_Overrun <= 1'b1;
            end
          end
          default: r_State <= S_SYNC;
        endcase
      end else if (w_Expire) begin
        r_Timeout <= 1'b1;
        r_State   <= S_SYNC;
      end
    end
  end

  assign o_Frame_Valid = r_Valid;
  assign o_Addr        = r_OutAddr;
  assign o_Len         = r_OutLen;
  assign o_Data        = r_OutData;
  assign o_Chk_Err     = r_ChkErr;
  assign o_Len_Err     = r_LenErr;
  assign o_Timeout     = r_Timeout;
  assign o_Overrun     = r_Overrun;
  assign o_Busy        = w_Busy;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench for uart_frame_ctrl: directed frames plus random frames
// checked against a frame-level model of the held frame and error pulses.
module tb_uart_frame_ctrl;

  logic        i_Clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        i_Rx_Active = 1'b0;
  logic        i_Frame_Ready = 1'b0;
  logic        o_Frame_Valid;
  logic [7:0]  o_Addr;
  logic [3:0]  o_Len;
  logic [63:0] o_Data;
  logic        o_Chk_Err;
  logic        o_Len_Err;
  logic        o_Timeout;
  logic        o_Overrun;
  logic        o_Busy;

  int nChecks = 0;
  int nPass = 0;
  int nFail = 0;

  // pulse counts observed on the DUT, and counts the model expects
  int cChk = 0, cLen = 0, cTo = 0, cOvr = 0;
  int eChk = 0, eLen = 0, eTo = 0, eOvr = 0;

  // model of the held frame
  bit          mValid = 1'b0;
  logic [7:0]  mAddr = 8'h00;
  logic [3:0]  mLen = 4'h0;
  logic [63:0] mData = 64'h0;

  always #5 i_Clock = ~i_Clock;

  uart_frame_ctrl #(
    .SYNC_BYTE   (8'hA5),
    .MAX_LEN     (8),
    .TIMEOUT_CLKS(1000)
  ) dut (
    .i_Clock      (i_Clock),
    .rst_n        (rst_n),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_Byte    (i_Rx_Byte),
    .i_Rx_Active  (i_Rx_Active),
    .i_Frame_Ready(i_Frame_Ready),
    .o_Frame_Valid(o_Frame_Valid),
    .o_Addr       (o_Addr),
    .o_Len        (o_Len),
    .o_Data       (o_Data),
    .o_Chk_Err    (o_Chk_Err),
    .o_Len_Err    (o_Len_Err),
    .o_Timeout    (o_Timeout),
    .o_Overrun    (o_Overrun),
    .o_Busy       (o_Busy)
  );

  // count every cycle an error pulse is high, shortly after each edge
  always @(posedge i_Clock) begin
    #1;
    if (o_Chk_Err) cChk++;
    if (o_Len_Err) cLen++;
    if (o_Timeout) cTo++;
    if (o_Overrun) cOvr++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic rdy);
    @(negedge i_Clock);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    i_Frame_Ready = rdy;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
    i_Frame_Ready = 1'b0;
  endtask

  task automatic idleCycles(input int n, input logic active);
    i_Rx_Active = active;
    repeat (n) @(negedge i_Clock);
    i_Rx_Active = 1'b0;
  endtask

  task automatic doReset();
    @(negedge i_Clock);
    rst_n = 1'b0;
    @(negedge i_Clock);
    rst_n = 1'b1;
    mValid = 1'b0;
  endtask

  task automatic acceptFrame(input string tag);
    @(negedge i_Clock);
    i_Frame_Ready = 1'b1;
    @(negedge i_Clock);
    i_Frame_Ready = 1'b0;
    mValid = 1'b0;
    checkOutput({tag, ".validAfterAccept"}, 64'(o_Frame_Valid), 64'd0);
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".valid"}, 64'(o_Frame_Valid), 64'(mValid));
    if (mValid) begin
      checkOutput({tag, ".addr"}, 64'(o_Addr), 64'(mAddr));
      checkOutput({tag, ".len"}, 64'(o_Len), 64'(mLen));
      checkOutput({tag, ".data"}, o_Data, mData);
    end
    checkOutput({tag, ".chkCount"}, 64'(cChk), 64'(eChk));
    checkOutput({tag, ".lenCount"}, 64'(cLen), 64'(eLen));
    checkOutput({tag, ".toCount"}, 64'(cTo), 64'(eTo));
    checkOutput({tag, ".ovrCount"}, 64'(cOvr), 64'(eOvr));
    checkOutput({tag, ".busy"}, 64'(o_Busy), 64'd0);
  endtask

  // Sends one frame, then updates the model from the frame rules: a good
  // checksum loads when nothing is held or the consumer accepts the same
  // cycle, otherwise it is an overrun; a bad checksum only reports an error.
  task automatic sendFrame(input logic [7:0] addr, input int len, input logic [63:0] payload,
                           input bit corrupt, input bit rdy, input bit gaps);
    logic [7:0] chk;
    logic [7:0] pb;
    chk = addr ^ 8'(len);
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(addr, 1'b0);
    if (gaps) idleCycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
    applyStimulus(8'(len), 1'b0);
    for (int k = 0; k < len; k++) begin
      pb = payload[8*k +: 8];
      chk = chk ^ pb;
      if (gaps) idleCycles($urandom_range(0, 2), 1'($urandom_range(0, 1)));
      applyStimulus(pb, 1'b0);
    end
    if (corrupt) chk = chk ^ 8'($urandom_range(1, 255));
    applyStimulus(chk, rdy);
    if (corrupt) begin
      eChk++;
      if (rdy) mValid = 1'b0;
    end else if (!mValid || rdy) begin
      mValid = 1'b1;
      mAddr = addr;
      mLen = 4'(len);
      mData = 64'h0;
      for (int k = 0; k < len; k++) mData[8*k +: 8] = payload[8*k +: 8];
    end else begin
      eOvr++;
    end
  endtask

  function automatic logic [63:0] randPayload(input int len);
    logic [63:0] p;
    p = 64'h0;
    for (int k = 0; k < len; k++) p[8*k +: 8] = 8'($urandom);
    return p;
  endfunction

  initial begin
    int len;
    logic [7:0] junk;

    // reset values
    doReset();
    checkOutput("reset.valid", 64'(o_Frame_Valid), 64'd0);
    checkOutput("reset.addr", 64'(o_Addr), 64'd0);
    checkOutput("reset.len", 64'(o_Len), 64'd0);
    checkOutput("reset.data", o_Data, 64'd0);
    checkOutput("reset.busy", 64'(o_Busy), 64'd0);
    checkOutput("reset.pulses", 64'({o_Chk_Err, o_Len_Err, o_Timeout, o_Overrun}), 64'd0);

    // the reference good frame
    sendFrame(8'h10, 2, 64'h2211, 1'b0, 1'b0, 1'b0);
    checkOutput("good.addrConst", 64'(o_Addr), 64'h10);
    checkOutput("good.dataConst", o_Data, 64'h0000_0000_0000_2211);
    idleCycles(3, 1'b0);
    checkState("good");
    acceptFrame("good");

    // bad checksum
    applyStimulus(8'hA5, 1'b0);
    checkOutput("bad.busyMid", 64'(o_Busy), 64'd1);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h20, 1'b0);
    eChk++;
    checkOutput("bad.pulseNow", 64'(o_Chk_Err), 64'd1);
    idleCycles(2, 1'b0);
    checkState("bad");

    // length too large, then zero
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h09, 1'b0);
    eLen++;
    checkOutput("len9.pulseNow", 64'(o_Len_Err), 64'd1);
    idleCycles(1, 1'b0);
    checkState("len9");
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h00, 1'b0);
    eLen++;
    idleCycles(1, 1'b0);
    checkState("len0");

    // maximum length accepted
    sendFrame(8'h3C, 8, 64'h8877_6655_4433_2211, 1'b0, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    checkState("len8");
    acceptFrame("len8");

    // silence after the address byte times out exactly once
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    idleCycles(1100, 1'b0);
    eTo++;
    checkState("timeout");
    sendFrame(8'h55, 3, randPayload(3), 1'b0, 1'b0, 1'b1);
    idleCycles(1, 1'b0);
    checkState("afterTimeout");
    acceptFrame("afterTimeout");

    // a long gap just short of the limit, and a long mid-character stall
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h42, 1'b0);
    applyStimulus(8'h02, 1'b0);
    idleCycles(995, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h42 ^ 8'h02 ^ 8'h01 ^ 8'h02, 1'b0);
    mValid = 1'b1; mAddr = 8'h42; mLen = 4'd2; mData = 64'h0201;
    idleCycles(1, 1'b0);
    checkState("nearTimeout");
    acceptFrame("nearTimeout");
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h77, 1'b0);
    idleCycles(1500, 1'b1);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h99, 1'b0);
    applyStimulus(8'h77 ^ 8'h01 ^ 8'h99, 1'b0);
    mValid = 1'b1; mAddr = 8'h77; mLen = 4'd1; mData = 64'h99;
    idleCycles(1, 1'b0);
    checkState("activeStall");
    acceptFrame("activeStall");

    // overrun while a frame is held, then replacement with ready on CHK
    sendFrame(8'h01, 2, randPayload(2), 1'b0, 1'b0, 1'b1);
    sendFrame(8'h02, 4, randPayload(4), 1'b0, 1'b0, 1'b1);
    checkOutput("overrun.pulseNow", 64'(o_Overrun), 64'd1);
    idleCycles(1, 1'b0);
    checkState("overrun");
    sendFrame(8'h03, 5, randPayload(5), 1'b0, 1'b1, 1'b1);
    idleCycles(1, 1'b0);
    checkState("replace");

    // reset mid-frame drops the partial frame and the held frame
    applyStimulus(8'hA5, 1'b0);
    applyStimulus(8'h10, 1'b0);
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h11, 1'b0);
    doReset();
    checkOutput("midReset.valid", 64'(o_Frame_Valid), 64'd0);
    checkOutput("midReset.addr", 64'(o_Addr), 64'd0);
    checkOutput("midReset.len", 64'(o_Len), 64'd0);
    checkOutput("midReset.data", o_Data, 64'd0);
    checkOutput("midReset.busy", 64'(o_Busy), 64'd0);
    sendFrame(8'h10, 2, 64'h2211, 1'b0, 1'b0, 1'b0);
    idleCycles(1, 1'b0);
    checkState("afterReset");

    // random frames with junk, corruption, and random consumer behaviour
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        applyStimulus(junk, 1'b0);
      end
      len = $urandom_range(1, 8);
      sendFrame(8'($urandom), len, randPayload(len), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'b1);
      idleCycles(1, 1'b0);
      checkState($sformatf("rand%0d", it));
      if ($urandom_range(0, 2) == 0) acceptFrame($sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
